// File: rtl/backscatter_sync.sv
// Backscatter wake-up synchroniser and framed bit-stream transmitter (IDLE/ARMED/TX).
// Define BACKSCATTER_SCRAMBLER_EN to compile in the payload scrambler.
module backscatter_sync #(
  parameter int unsigned CLK_DIV      = 100,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PREAMBLE_LEN = 432,
  parameter int unsigned TRAILER_LEN  = 32,
  parameter logic [7:0]  PATTERN      = 8'hF0
) (
  input  logic             clki,
  input  logic             rst,
  input  logic             wake_up,
  input  logic             comp_out,
  input  logic             use_stage2,
  input  logic [CNT_W-1:0] pkt_duration,
  input  logic [CNT_W-1:0] fixed_delay,
  input  logic [CNT_W-1:0] timeout,
  output logic             WU_valid,
  output logic             data_clk_enb,
  output logic             data_clk,
  output logic             T_0,
  output logic             T_1,
  output logic             bs_switch,
  output logic             done
);

  localparam logic [CNT_W-1:0] DivLast = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W:0]   PreLen  = (CNT_W + 1)'(PREAMBLE_LEN);
  localparam logic [CNT_W:0]   TrlLen  = (CNT_W + 1)'(TRAILER_LEN);
  localparam logic [2:0]       PreLo   = 3'(PREAMBLE_LEN % 8);

  typedef enum logic [1:0] {StIdle, StArmed, StTx} state_e;

  state_e           r_state, w_state_nxt;
  logic [2:0]       r_wu_sync, r_co_sync;
  logic             r_live, r_wu_arm;
  logic [CNT_W-1:0] r_tim_cnt, r_bit_cnt, r_dur, r_div;
  logic             r_data_clk, r_t1, r_bs_switch, r_done;
  logic             w_wu_edge, w_co_edge, w_trig, w_tmo;
  logic             w_in_pre, w_in_pay, w_pat_bit;
  logic [2:0]       w_pat_idx;

  // wake_up edges are only honoured once the synchroniser has seen the line low after reset,
  // so a level held high through reset release never looks like a rising edge.
  assign w_wu_edge = r_wu_arm & (r_wu_sync[2:1] == 2'b01);
  assign w_co_edge = (r_co_sync[2:1] == 2'b01);

  assign w_in_pre  = {1'b0, r_bit_cnt} < PreLen;
  assign w_in_pay  = ~w_in_pre & (({1'b0, r_bit_cnt} + TrlLen) < {1'b0, r_dur});
  assign w_pat_idx = 3'd7 - (r_bit_cnt[2:0] - PreLo);
  assign w_pat_bit = PATTERN[w_pat_idx];

`ifdef BACKSCATTER_SCRAMBLER_EN
  // Bit 7 of the post-shift word is the old bit 6, so only seven bits need storage.
  logic [6:0] r_scr;
  logic [7:0] w_scr_shift;
  logic       w_scr_fb;
  assign w_scr_shift = {r_scr, r_t1};
  assign w_scr_fb    = w_scr_shift[0] ^ w_scr_shift[3] ^ w_scr_shift[4] ^ w_scr_shift[6] ^
                       w_scr_shift[7];
`endif

  assign WU_valid     = (r_state == StArmed);
  assign data_clk_enb = (r_state == StTx);
  assign data_clk     = r_data_clk;
  assign T_0          = 1'b0;
  assign T_1          = r_t1;
  assign bs_switch    = r_bs_switch;
  assign done         = r_done;

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      r_wu_sync <= '0;
      r_co_sync <= '0;
      r_live    <= 1'b0;
      r_wu_arm  <= 1'b0;
    end else begin
      r_wu_sync <= {r_wu_sync[1:0], wake_up};
      r_co_sync <= {r_co_sync[1:0], comp_out};
      r_live    <= 1'b1;
      if (r_live && !r_wu_sync[0]) r_wu_arm <= 1'b1;
    end
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_trig      = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      StIdle: if (w_wu_edge) w_state_nxt = StArmed;
      StArmed: begin
        w_trig = use_stage2 ? w_co_edge : (r_tim_cnt == fixed_delay);
        w_tmo  = (r_tim_cnt == timeout);
        if (w_trig)     w_state_nxt = StTx;
        else if (w_tmo) w_state_nxt = StIdle;
      end
      StTx: if (r_bit_cnt == r_dur) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      r_tim_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_dur       <= '0;
      r_div       <= '0;
      r_data_clk  <= 1'b0;
      r_t1        <= 1'b0;
      r_bs_switch <= 1'b1;
      r_done      <= 1'b0;
`ifdef BACKSCATTER_SCRAMBLER_EN
      r_scr       <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_wu_edge) begin
            r_tim_cnt   <= '0;
            r_bs_switch <= 1'b0;
          end
        end
        StArmed: begin
          r_tim_cnt <= r_tim_cnt + CNT_W'(1);
          if (w_state_nxt == StTx) begin
            r_dur      <= pkt_duration;
            r_bit_cnt  <= '0;
            r_data_clk <= 1'b0;
            r_div      <= DivLast;
          end else if (w_state_nxt == StIdle) begin
            r_bs_switch <= 1'b1;
          end
        end
        StTx: begin
          if (w_state_nxt == StIdle) begin
            r_done      <= 1'b1;
            r_bs_switch <= 1'b1;
            r_data_clk  <= 1'b0;
            r_t1        <= 1'b0;
          end else if (r_div == DivLast) begin
            r_div      <= '0;
            r_data_clk <= ~r_data_clk;
            if (r_data_clk) begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end else if (w_in_pre) begin
              r_t1 <= 1'b0;
`ifdef BACKSCATTER_SCRAMBLER_EN
              r_scr <= '0;
`endif
            end else if (w_in_pay) begin
`ifdef BACKSCATTER_SCRAMBLER_EN
              r_scr <= w_scr_shift[6:0];
              r_t1  <= w_pat_bit ^ w_scr_fb;
`else
              r_t1  <= w_pat_bit;
`endif
            end else begin
              r_t1 <= 1'b0;
            end
          end else begin
            r_div <= r_div + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_backscatter_sync.sv
// Directed and randomized checks of backscatter_sync against a bit-level packet model.
module tb_backscatter_sync;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned CNT_W   = 16;
  localparam int          PRE     = 4;
  localparam int          TRL     = 2;
  localparam logic [7:0]  PAT     = 8'hF0;
  localparam bit ScrEn =
`ifdef BACKSCATTER_SCRAMBLER_EN
    1'b1;
`else
    1'b0;
`endif

  logic             clki = 1'b0;
  logic             rst = 1'b1;
  logic             wake_up = 1'b0;
  logic             comp_out = 1'b0;
  logic             use_stage2 = 1'b0;
  logic [CNT_W-1:0] pkt_duration = '0;
  logic [CNT_W-1:0] fixed_delay = '0;
  logic [CNT_W-1:0] timeout = '0;
  logic WU_valid, data_clk_enb, data_clk, T_0, T_1, bs_switch, done;

  int n_cmp = 0;
  int n_err = 0;

  backscatter_sync #(
    .CLK_DIV(CLK_DIV), .CNT_W(CNT_W), .PREAMBLE_LEN(PRE), .TRAILER_LEN(TRL), .PATTERN(PAT)
  ) u_dut (
    .clki(clki), .rst(rst), .wake_up(wake_up), .comp_out(comp_out), .use_stage2(use_stage2),
    .pkt_duration(pkt_duration), .fixed_delay(fixed_delay), .timeout(timeout),
    .WU_valid(WU_valid), .data_clk_enb(data_clk_enb), .data_clk(data_clk), .T_0(T_0),
    .T_1(T_1), .bs_switch(bs_switch), .done(done)
  );

  always #5 clki = ~clki;

  // Output monitor, sampled on the inactive edge.
  int   wu_cyc, tx_cyc, done_cnt, bs_low, bad_cnt;
  logic prev_dc = 1'b0;
  logic t1_q[$];
  logic [31:0] last_bits;

  always @(negedge clki) begin
    if (WU_valid === 1'b1) wu_cyc++;
    if (data_clk_enb === 1'b1) tx_cyc++;
    if (done === 1'b1) done_cnt++;
    if (bs_switch === 1'b0) bs_low++;
    if (data_clk === 1'b1 && prev_dc === 1'b0) t1_q.push_back(T_1);
    if (data_clk === 1'b1 && data_clk_enb !== 1'b1) bad_cnt++;
    if (WU_valid === 1'b1 && data_clk_enb === 1'b1) bad_cnt++;
    if (T_0 !== 1'b0) bad_cnt++;
    prev_dc = data_clk;
  end

  task automatic clr_mon();
    wu_cyc = 0; tx_cyc = 0; done_cnt = 0; bs_low = 0; bad_cnt = 0;
    t1_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clki);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected T_1 sequence, MSB = first bit, built directly from the framing rules.
  function automatic logic [31:0] model_bits(input int dur);
    logic [7:0]  pat = PAT;
    logic [7:0]  s = '0;
    logic [31:0] v = '0;
    logic        prev = 1'b0;
    logic        raw, b;
    for (int k = 0; k < dur; k++) begin
      if (k < PRE) begin
        b = 1'b0;
        s = '0;
      end else if (k + TRL < dur) begin
        raw = pat[7 - ((k - PRE) % 8)];
        s   = {s[6:0], prev};
        b   = ScrEn ? (raw ^ s[0] ^ s[3] ^ s[4] ^ s[6] ^ s[7]) : raw;
      end else begin
        b = 1'b0;
      end
      v    = {v[30:0], b};
      prev = b;
    end
    return v;
  endfunction

  // Posedges from the first sampling of wake_up high until WU_valid is seen.
  task automatic wait_armed(output int lat);
    lat = 99;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      if (WU_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic wait_end(input int budget, input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (WU_valid === 1'b0 && data_clk_enb === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_pkt(input string tag, input int exp_wu, input int dur, input bit tx);
    int          exp_tx = tx ? ((dur == 0) ? 1 : CLK_DIV * dur) : 0;
    logic [31:0] obs = '0;
    foreach (t1_q[k]) obs = {obs[30:0], t1_q[k]};
    last_bits = obs;
    check({tag, "_wu_cycles"}, 32'(wu_cyc), 32'(exp_wu));
    check({tag, "_tx_cycles"}, 32'(tx_cyc), 32'(exp_tx));
    check({tag, "_done"}, 32'(done_cnt), tx ? 32'd1 : 32'd0);
    check({tag, "_bs_low"}, 32'(bs_low), 32'(exp_wu + exp_tx));
    check({tag, "_rises"}, 32'(t1_q.size()), tx ? 32'(dur) : 32'd0);
    check({tag, "_bits"}, obs, tx ? model_bits(dur) : 32'd0);
    check({tag, "_protocol"}, 32'(bad_cnt), 32'd0);
  endtask

  task automatic run_stage1(input int delay, input int dur, input bit glitch);
    int lat;
    bit ok = 1'b0;
    clr_mon();
    use_stage2 = 1'b0; fixed_delay = CNT_W'(delay); pkt_duration = CNT_W'(dur); timeout = '1;
    wake_up = 1'b1;
    wait_armed(lat);
    check("s1_latency", 32'(lat), 32'd3);
    if (glitch) begin
      for (int c = 0; c < delay + 8; c++) begin
        tick(1);
        if (data_clk_enb === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      check("s1_tx_entry", 32'(ok), 32'd1);
      // A fresh wake_up edge mid-packet must be ignored.
      wake_up = 1'b0; tick(4); wake_up = 1'b1;
    end
    wait_end(delay + CLK_DIV * dur + 20, "s1_end");
    tick(8);
    wake_up = 1'b0;
    check_pkt("s1", delay + 1, dur, 1'b1);
    tick(4);
  endtask

  task automatic run_stage2(input int tmo, input int j, input int dur);
    int lat;
    bit hit = (j >= 2 && j <= tmo);
    clr_mon();
    // A comparator edge while idle must not leave anything behind.
    comp_out = 1'b1; tick(4); comp_out = 1'b0; tick(4);
    use_stage2 = 1'b1; fixed_delay = '0; timeout = CNT_W'(tmo); pkt_duration = CNT_W'(dur);
    wake_up = 1'b1;
    wait_armed(lat);
    check("s2_latency", 32'(lat), 32'd3);
    // Now in the tim_count==0 cycle; edge detection lags the drive by two edges.
    if (j >= 2) begin
      if (j > 2) tick(j - 2);
      comp_out = 1'b1;
    end
    wait_end(tmo + CLK_DIV * dur + 20, "s2_end");
    tick(8);
    wake_up = 1'b0; comp_out = 1'b0;
    check_pkt("s2", hit ? j + 1 : tmo + 1, dur, hit);
    tick(4);
  endtask

  initial begin
    int  d, n, t, j;
    bit  ok;
    clr_mon();
    tick(3);
    check("rst_wu_valid", 32'(WU_valid), 32'd0);
    check("rst_tx_enb", 32'(data_clk_enb), 32'd0);
    check("rst_data_clk", 32'(data_clk), 32'd0);
    check("rst_t1", 32'(T_1), 32'd0);
    check("rst_t0", 32'(T_0), 32'd0);
    check("rst_bs_switch", 32'(bs_switch), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick(4);

    run_stage1(10, 16, 1'b1);
    if (!ScrEn) check("framing_raw", last_bits, 32'h0000_0F0C);
    run_stage2(50, -1, 8);
    run_stage2(50, 50, 8);
    run_stage1(3, 0, 1'b0);

    // Reset in the middle of a packet, with wake_up held high through release.
    clr_mon();
    use_stage2 = 1'b0; fixed_delay = CNT_W'(3); pkt_duration = CNT_W'(16); timeout = '1;
    wake_up = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick(1);
      if (t1_q.size() >= 8) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_bit7_reached", 32'(ok), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wu_valid", 32'(WU_valid), 32'd0);
    check("mid_rst_tx_enb", 32'(data_clk_enb), 32'd0);
    check("mid_rst_data_clk", 32'(data_clk), 32'd0);
    check("mid_rst_t1", 32'(T_1), 32'd0);
    check("mid_rst_bs_switch", 32'(bs_switch), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    tick(3);
    rst = 1'b0;
    clr_mon();
    tick(10);
    check("held_wake_no_arm", 32'(wu_cyc + tx_cyc), 32'd0);
    wake_up = 1'b0;
    tick(4);
    run_stage1(3, 16, 1'b0);

    for (int i = 0; i < 6; i++) begin
      d = int'($urandom_range(2, 12));
      n = int'($urandom_range(0, 30));
      run_stage1(d, n, n >= 4);
    end
    for (int i = 0; i < 4; i++) begin
      t = int'($urandom_range(10, 30));
      j = int'($urandom_range(2, t + 3));
      n = int'($urandom_range(0, 20));
      run_stage2(t, j, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
